// File: rtl/dmu_sii_req_tx.sv
// DMU -> SII request transmitter: header/payload sequencing, write-credit tracking, lane parity.
// Optional feature macro DMU_SII_TX_PARITY_INJ_EN adds inj_par_err to corrupt parity lane 0.
package dmu_sii_req_tx_pkg;
  localparam int unsigned HDR_W   = 128;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned BE_W    = 16;
  localparam int unsigned PAR_W   = 8;
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TAG_LSB = 64;
  localparam int unsigned CRD_W   = 5;

  localparam logic [1:0] REQ_RD    = 2'b00;
  localparam logic [1:0] REQ_WR    = 2'b01;
  localparam logic [1:0] REQ_RSV   = 2'b10;
  localparam logic [1:0] REQ_MONDO = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } pld_beat_t;
endpackage

module dmu_sii_req_tx
  import dmu_sii_req_tx_pkg::*;
#(
  parameter int unsigned WR_CREDITS = 16
) (
  input  logic              iol2clk,
  input  logic              rst,
`ifdef DMU_SII_TX_PARITY_INJ_EN
  input  logic              inj_par_err,
`endif
  input  logic              req_vld,
  input  logic [1:0]        req_type,
  input  logic              req_bypass,
  input  logic [HDR_W-1:0]  req_hdr,
  output logic              req_rdy,
  input  logic              pld_vld,
  output logic              pld_rdy,
  input  logic [DATA_W-1:0] pld_data,
  input  logic [BE_W-1:0]   pld_be,
  output logic              dmu_sii_hdr_vld,
  output logic              dmu_sii_reqbypass,
  output logic              dmu_sii_datareq,
  output logic              dmu_sii_datareq16,
  output logic [DATA_W-1:0] dmu_sii_data,
  output logic [PAR_W-1:0]  dmu_sii_parity,
  output logic [BE_W-1:0]   dmu_sii_be,
  input  logic              sii_dmu_wrack_vld,
  input  logic [TAG_W-1:0]  sii_dmu_wrack_tag,
  output logic [CRD_W-1:0]  wr_credits,
  output logic [1:0]        err_sticky
);

  localparam int unsigned FIFO_D = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned NTAGS  = 16;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(WR_CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD} state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  pld_beat_t         mem_q [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [NTAGS-1:0]  outst_q, outst_d;
  logic [1:0]        err_q, err_d;
  logic              hdr_vld_q, hdr_vld_d;
  logic              bypass_q, bypass_d;
  logic              datareq_q, datareq_d;
  logic              datareq16_q, datareq16_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [PAR_W-1:0]  par_q, par_d;

  logic [BEAT_W-1:0] need_c;
  logic [TAG_W-1:0]  req_tag;
  logic is_wr, is_rsv, wr_ok, fifo_ok, eligible, accept, wr_acc;
  logic push, pop, ack_ok, ack_bad;

  // Payload beats each request type consumes from the FIFO
  always_comb begin
    need_c = '0;
    case (req_type)
      REQ_WR:    need_c = BEAT_W'(4);
      REQ_MONDO: need_c = BEAT_W'(1);
      default:   need_c = '0;
    endcase
  end

  assign req_tag  = req_hdr[TAG_LSB +: TAG_W];
  assign is_wr    = (req_type == REQ_WR);
  assign is_rsv   = (req_type == REQ_RSV);
  assign wr_ok    = !is_wr || ((credits_q != '0) && !outst_q[req_tag]);
  assign fifo_ok  = (cnt_q >= need_c);
  // A new request may start once no payload beats remain to be sent
  assign eligible = (beats_q == '0);
  assign req_rdy  = !rst && eligible && fifo_ok && wr_ok;
  assign accept   = req_vld && req_rdy;
  assign wr_acc   = accept && is_wr;
  assign pld_rdy  = !rst && (cnt_q != CNT_W'(FIFO_D));
  assign push     = pld_vld && pld_rdy;
  assign pop      = (state_q != S_IDLE) && (beats_q != '0);
  assign ack_ok   = sii_dmu_wrack_vld && outst_q[sii_dmu_wrack_tag];
  assign ack_bad  = sii_dmu_wrack_vld && !outst_q[sii_dmu_wrack_tag];
  assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

  // Next bus cycle: payload beat, new header, or idle
  always_comb begin
    state_d     = S_IDLE;
    beats_d     = '0;
    hdr_vld_d   = 1'b0;
    bypass_d    = 1'b0;
    datareq_d   = 1'b0;
    datareq16_d = 1'b0;
    data_d      = '0;
    be_d        = '0;
    par_d       = '0;
    if (pop) begin
      state_d = S_PLD;
      beats_d = beats_q - BEAT_W'(1);
      data_d  = mem_q[rd_ptr_q].data;
      be_d    = mem_q[rd_ptr_q].be;
    end else if (accept && !is_rsv) begin
      state_d     = S_HDR;
      beats_d     = need_c;
      hdr_vld_d   = 1'b1;
      bypass_d    = req_bypass;
      datareq_d   = (req_type != REQ_RD);
      datareq16_d = (req_type == REQ_MONDO);
      data_d      = req_hdr;
    end
    for (int i = 0; i < PAR_W; i++) begin
      par_d[i] = ^data_d[LANE_W*i +: LANE_W];
    end
  end

  // Credit pool, outstanding-tag bitmap and sticky errors
  always_comb begin
    outst_d   = outst_q;
    credits_d = credits_q;
    err_d     = err_q;
    if (ack_ok) outst_d[sii_dmu_wrack_tag] = 1'b0;
    if (wr_acc) outst_d[req_tag] = 1'b1;
    if (wr_acc && !ack_ok) begin
      credits_d = credits_q - CRD_W'(1);
    end else if (ack_ok && !wr_acc && (credits_q < CRD_MAX)) begin
      credits_d = credits_q + CRD_W'(1);
    end
    if (ack_bad) err_d[1] = 1'b1;
    if (accept && is_rsv) err_d[0] = 1'b1;
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beats_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      credits_q   <= CRD_MAX;
      outst_q     <= '0;
      err_q       <= '0;
      hdr_vld_q   <= 1'b0;
      bypass_q    <= 1'b0;
      datareq_q   <= 1'b0;
      datareq16_q <= 1'b0;
      data_q      <= '0;
      be_q        <= '0;
      par_q       <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
      cnt_q       <= cnt_d;
      credits_q   <= credits_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
      hdr_vld_q   <= hdr_vld_d;
      bypass_q    <= bypass_d;
      datareq_q   <= datareq_d;
      datareq16_q <= datareq16_d;
      data_q      <= data_d;
      be_q        <= be_d;
      par_q       <= par_d;
    end
  end

  always_ff @(posedge iol2clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: pld_data, be: pld_be};
  end

  assign dmu_sii_hdr_vld   = hdr_vld_q;
  assign dmu_sii_reqbypass = bypass_q;
  assign dmu_sii_datareq   = datareq_q;
  assign dmu_sii_datareq16 = datareq16_q;
  assign dmu_sii_data      = data_q;
  assign dmu_sii_be        = be_q;
  assign wr_credits        = credits_q;
  assign err_sticky        = err_q;

`ifdef DMU_SII_TX_PARITY_INJ_EN
  assign dmu_sii_parity = par_q ^ {{(PAR_W-1){1'b0}}, inj_par_err && (state_q != S_IDLE)};
`else
  assign dmu_sii_parity = par_q;
`endif

endmodule

// File: tb/tb_dmu_sii_req_tx.sv
// Self-checking bench for dmu_sii_req_tx: vector table + per-cycle bus scoreboard.
module tb_dmu_sii_req_tx;

  logic         iol2clk;
  logic         rst;
  logic         req_vld;
  logic [1:0]   req_type;
  logic         req_bypass;
  logic [127:0] req_hdr;
  logic         req_rdy;
  logic         pld_vld;
  logic         pld_rdy;
  logic [127:0] pld_data;
  logic [15:0]  pld_be;
  logic         dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16;
  logic [127:0] dmu_sii_data;
  logic [7:0]   dmu_sii_parity;
  logic [15:0]  dmu_sii_be;
  logic         sii_dmu_wrack_vld;
  logic [3:0]   sii_dmu_wrack_tag;
  logic [4:0]   wr_credits;
  logic [1:0]   err_sticky;
`ifdef DMU_SII_TX_PARITY_INJ_EN
  logic         inj_par_err;
  initial inj_par_err = 1'b0;
`endif

  dmu_sii_req_tx #(.WR_CREDITS(16)) dut (
    .iol2clk(iol2clk), .rst(rst),
`ifdef DMU_SII_TX_PARITY_INJ_EN
    .inj_par_err(inj_par_err),
`endif
    .req_vld(req_vld), .req_type(req_type), .req_bypass(req_bypass), .req_hdr(req_hdr),
    .req_rdy(req_rdy), .pld_vld(pld_vld), .pld_rdy(pld_rdy), .pld_data(pld_data),
    .pld_be(pld_be), .dmu_sii_hdr_vld(dmu_sii_hdr_vld), .dmu_sii_reqbypass(dmu_sii_reqbypass),
    .dmu_sii_datareq(dmu_sii_datareq), .dmu_sii_datareq16(dmu_sii_datareq16),
    .dmu_sii_data(dmu_sii_data), .dmu_sii_parity(dmu_sii_parity), .dmu_sii_be(dmu_sii_be),
    .sii_dmu_wrack_vld(sii_dmu_wrack_vld), .sii_dmu_wrack_tag(sii_dmu_wrack_tag),
    .wr_credits(wr_credits), .err_sticky(err_sticky)
  );

  initial iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  typedef struct packed {
    logic         hv;
    logic         byp;
    logic         dr;
    logic         dr16;
    logic [127:0] data;
    logic [7:0]   par;
    logic [15:0]  be;
  } bus_t;

  typedef struct {
    logic [1:0]   t;
    logic         byp;
    logic [127:0] hdr;
    int           nb;
    bit           hv, dr, dr16;
    logic [127:0] base;
    bit           ack;
    logic [4:0]   cred;
    logic [1:0]   err;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  bus_t         exp_q[$];
  logic [143:0] fifo_m[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;

  function automatic logic [7:0] calc_par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i] = 1'b0;
      for (int k = 0; k < 16; k++) p[i] = p[i] ^ d[16*i+k];
    end
    return p;
  endfunction

  function automatic bus_t cur_bus();
    bus_t b;
    b.hv = dmu_sii_hdr_vld; b.byp = dmu_sii_reqbypass;
    b.dr = dmu_sii_datareq; b.dr16 = dmu_sii_datareq16;
    b.data = dmu_sii_data; b.par = dmu_sii_parity; b.be = dmu_sii_be;
    return b;
  endfunction

  task automatic chk_bus(input string nm, input bus_t got, input bus_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got hv%0b byp%0b dr%0b%0b be=%h par=%h data=%h want hv%0b byp%0b dr%0b%0b be=%h par=%h data=%h",
               nm, $time, got.hv, got.byp, got.dr, got.dr16, got.be, got.par, got.data,
               want.hv, want.byp, want.dr, want.dr16, want.be, want.par, want.data);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, got, want);
    end
  endtask

  // Every cycle: bus must equal next scoreboard entry, or idle when none pending
  initial begin : monitor
    bus_t got, want;
    forever begin
      @(posedge iol2clk); #1;
      if (mon_en) begin
        got = cur_bus();
        if (exp_q.size() != 0) want = exp_q.pop_front();
        else want = '0;
        chk_bus("bus", got, want);
      end
    end
  end

  task automatic push_beat(input logic [127:0] d, input logic [15:0] b);
    int n;
    n = 0;
    pld_vld = 1'b1; pld_data = d; pld_be = b;
    @(negedge iol2clk);
    while (!pld_rdy && n < 50) begin @(negedge iol2clk); n++; end
    if (pld_rdy) fifo_m.push_back({d, b});
    else chk("pld_rdy timeout", 32'(pld_rdy), 32'd1);
    @(posedge iol2clk); #3;
    pld_vld = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic byp, input logic [127:0] hdr,
                       input bit hv, input bit dr, input bit dr16, input int nb,
                       input int max_wait, output bit acc, output int waited);
    bus_t         e;
    logic [143:0] m;
    acc = 1'b0; waited = 0;
    req_vld = 1'b1; req_type = t; req_bypass = byp; req_hdr = hdr;
    while (!acc && waited < max_wait) begin
      @(negedge iol2clk);
      if (req_rdy) acc = 1'b1;
      else waited++;
    end
    if (acc && hv) begin
      e.hv = 1'b1; e.byp = byp; e.dr = dr; e.dr16 = dr16;
      e.data = hdr; e.par = calc_par(hdr); e.be = '0;
      exp_q.push_back(e);
      for (int j = 0; j < nb; j++) begin
        if (fifo_m.size() != 0) begin
          m = fifo_m.pop_front();
          e = '0;
          e.data = m[143:16]; e.be = m[15:0]; e.par = calc_par(m[143:16]);
          exp_q.push_back(e);
        end
      end
    end
    @(posedge iol2clk); #3;
    req_vld = 1'b0;
  endtask

  task automatic wrack(input logic [3:0] tag);
    sii_dmu_wrack_vld = 1'b1; sii_dmu_wrack_tag = tag;
    @(posedge iol2clk); #3;
    sii_dmu_wrack_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge iol2clk); #3; n++; end
    chk("drain pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge iol2clk); #3;
  endtask

  task automatic preload4(input logic [127:0] base);
    for (int j = 0; j < 4; j++) push_beat(base + 128'(j), 16'hFFFF >> j);
  endtask

  function automatic logic [127:0] wr_hdr(input int tag);
    return {48'h0, 12'h0, 4'(tag), 64'h0000_0040_0000_1000 + 64'(tag)};
  endfunction

  initial begin : driver
    bit acc;
    int w;
    vecs[0] = '{2'b00, 1'b1, 128'h0000_0000_0000_0000_0000_0012_3456_7800, 0, 1'b1, 1'b0, 1'b0, 128'h0,  1'b0, 5'd16, 2'b00};
    vecs[1] = '{2'b01, 1'b0, {48'h0, 16'h0005, 64'h0000_0055_0000_1000},  4, 1'b1, 1'b1, 1'b0, 128'hA0, 1'b1, 5'd15, 2'b00};
    vecs[2] = '{2'b11, 1'b0, {48'h0, 16'h0000, 64'h0000_00FF_0000_0008},  1, 1'b1, 1'b1, 1'b1, {128{1'b1}}, 1'b0, 5'd16, 2'b00};
    vecs[3] = '{2'b00, 1'b0, {48'hCAFE, 16'h0003, 64'h0000_0001_2345_6780}, 0, 1'b1, 1'b0, 1'b0, 128'h0, 1'b0, 5'd16, 2'b00};
    vecs[4] = '{2'b01, 1'b1, {48'h0, 16'h000A, 64'h0000_0077_8899_AA00},  4, 1'b1, 1'b1, 1'b0, 128'h5555_0000_0000_0000_0000_0000_0000_0100, 1'b1, 5'd15, 2'b00};
    vecs[5] = '{2'b10, 1'b1, {48'h0, 16'h0006, 64'h0000_0011_2233_4400},  0, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0, 5'd16, 2'b01};

    rst = 1'b1; req_vld = 1'b0; req_type = 2'b00; req_bypass = 1'b0; req_hdr = '0;
    pld_vld = 1'b0; pld_data = '0; pld_be = '0;
    sii_dmu_wrack_vld = 1'b0; sii_dmu_wrack_tag = '0;

    // Reset state
    repeat (2) @(posedge iol2clk);
    #1 chk_bus("reset bus", cur_bus(), '0);
    @(negedge iol2clk);
    chk("reset pld_rdy", 32'(pld_rdy), 32'd0);
    chk("reset req_rdy", 32'(req_rdy), 32'd0);
    chk("reset credits", 32'(wr_credits), 32'd16);
    chk("reset err", 32'(err_sticky), 32'd0);
    @(posedge iol2clk); #3;
    rst = 1'b0; mon_en = 1'b1;
    @(negedge iol2clk);
    chk("pld_rdy after reset", 32'(pld_rdy), 32'd1);
    @(posedge iol2clk); #3;

    // Table of single transactions
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < vecs[i].nb; j++) push_beat(vecs[i].base + 128'(j), 16'hFFFF >> j);
      issue(vecs[i].t, vecs[i].byp, vecs[i].hdr, vecs[i].hv, vecs[i].dr, vecs[i].dr16,
            vecs[i].nb, 10, acc, w);
      chk($sformatf("vec%0d accept", i), 32'(acc), 32'd1);
      chk($sformatf("vec%0d wait", i), 32'(w), 32'd0);
      wait_drain();
      chk($sformatf("vec%0d credits", i), 32'(wr_credits), 32'(vecs[i].cred));
      chk($sformatf("vec%0d err", i), 32'(err_sticky), 32'(vecs[i].err));
      if (vecs[i].ack) begin
        wrack(vecs[i].hdr[67:64]);
        chk($sformatf("vec%0d credits after wrack", i), 32'(wr_credits), 32'd16);
      end
    end

    // Write then read: read accepted on last payload beat, header follows with no gap
    preload4(128'hB0);
    issue(2'b01, 1'b0, wr_hdr(1), 1'b1, 1'b1, 1'b0, 4, 10, acc, w);
    chk("b2b write accept", 32'(acc), 32'd1);
    issue(2'b00, 1'b1, 128'h0000_0000_0000_0000_0000_0099_8877_6600, 1'b1, 1'b0, 1'b0, 0, 10, acc, w);
    chk("b2b read accept", 32'(acc), 32'd1);
    chk("b2b read wait", 32'(w), 32'd4);
    issue(2'b00, 1'b0, 128'h0000_0000_0000_0000_0000_0011_0000_0040, 1'b1, 1'b0, 1'b0, 0, 10, acc, w);
    chk("read-read wait", 32'(w), 32'd0);
    wait_drain();
    wrack(4'd1);
    chk("b2b credits", 32'(wr_credits), 32'd16);

    // Exhaust credits with tags 0..15
    for (int t = 0; t < 16; t++) begin
      preload4(128'h1000 + 128'(t * 16));
      issue(2'b01, 1'b0, wr_hdr(t), 1'b1, 1'b1, 1'b0, 4, 10, acc, w);
      chk($sformatf("fill tag%0d accept", t), 32'(acc), 32'd1);
      wait_drain();
    end
    chk("credits exhausted", 32'(wr_credits), 32'd0);
    preload4(128'h3000);
    issue(2'b01, 1'b0, wr_hdr(3), 1'b1, 1'b1, 1'b0, 4, 5, acc, w);
    chk("17th write stalls", 32'(acc), 32'd0);
    wrack(4'd3);
    chk("credits after wrack3", 32'(wr_credits), 32'd1);
    issue(2'b01, 1'b0, wr_hdr(3), 1'b1, 1'b1, 1'b0, 4, 5, acc, w);
    chk("17th write accept", 32'(acc), 32'd1);
    chk("17th write wait", 32'(w), 32'd0);
    wait_drain();

    // Outstanding tag blocks even with a credit free; then same-cycle wrack + accept
    wrack(4'd7);
    preload4(128'h4000);
    issue(2'b01, 1'b0, wr_hdr(4), 1'b1, 1'b1, 1'b0, 4, 5, acc, w);
    chk("busy tag stalls", 32'(acc), 32'd0);
    sii_dmu_wrack_vld = 1'b1; sii_dmu_wrack_tag = 4'd4;
    issue(2'b01, 1'b0, wr_hdr(7), 1'b1, 1'b1, 1'b0, 4, 1, acc, w);
    sii_dmu_wrack_vld = 1'b0;
    chk("wrack+accept accept", 32'(acc), 32'd1);
    chk("wrack+accept credits", 32'(wr_credits), 32'd1);
    wait_drain();
    for (int t = 0; t < 16; t++) if (t != 4) wrack(4'(t));
    chk("credits restored", 32'(wr_credits), 32'd16);
    chk("no ack error yet", 32'(err_sticky), 32'd1);

    // Stray wrack
    wrack(4'd9);
    chk("stray wrack err", 32'(err_sticky), 32'd3);
    chk("stray wrack credits", 32'(wr_credits), 32'd16);

    // Reset during write beat 2
    preload4(128'hC0);
    issue(2'b01, 1'b0, wr_hdr(2), 1'b1, 1'b1, 1'b0, 4, 10, acc, w);
    chk("rst write accept", 32'(acc), 32'd1);
    repeat (3) @(posedge iol2clk);
    #3;
    chk("credits before rst", 32'(wr_credits), 32'd15);
    rst = 1'b1; mon_en = 1'b0;
    @(posedge iol2clk); #1;
    chk_bus("bus after rst", cur_bus(), '0);
    chk("credits after rst", 32'(wr_credits), 32'd16);
    chk("err after rst", 32'(err_sticky), 32'd0);
    chk("pld_rdy in rst", 32'(pld_rdy), 32'd0);
    exp_q.delete(); fifo_m.delete();
    #2 rst = 1'b0; mon_en = 1'b1;
    req_vld = 1'b1; req_type = 2'b11; req_bypass = 1'b0; req_hdr = 128'h77;
    @(negedge iol2clk);
    chk("fifo empty after rst", 32'(req_rdy), 32'd0);
    @(posedge iol2clk); #3;
    req_vld = 1'b0;
    push_beat(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 16'h0F0F);
    issue(2'b11, 1'b0, 128'h88, 1'b1, 1'b1, 1'b1, 1, 10, acc, w);
    chk("mondo after rst accept", 32'(acc), 32'd1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
